// File: rtl/p4_router_ing_arbiter.sv
// p4_router_ing_arbiter
//
// Packet-granular round-robin arbiter for the p4_router ingress path.
// Merges the per-port ingress packet buffers, already width-converted to
// DATA_BYTES, onto the single converged AXIS bus that feeds VNP4.
// One port owns the output for a whole packet. Every beat's tuser carries
// the index of the source port.
//
// Ports:
//   clk_ifc      - clock; all logic runs on its rising edge
//   sreset_ifc   - synchronous, active-high reset
//   in_tvalid    - per-port valid               [NUM_PORTS]
//   in_tready    - per-port ready               [NUM_PORTS]
//   in_tdata     - per-port data, port p at [p*DATA_BYTES*8 +: DATA_BYTES*8]
//   in_tkeep     - per-port byte keep           [NUM_PORTS*DATA_BYTES]
//   in_tlast     - per-port end of packet       [NUM_PORTS]
//   out_tvalid   - converged bus valid
//   out_tready   - converged bus ready
//   out_tdata    - data from the granted port
//   out_tkeep    - keep from the granted port
//   out_tlast    - last from the granted port
//   out_tuser    - granted port index, zero-extended
//   port_enable  - register-driven eligibility mask (1 = may be granted)
//   busy         - high while a packet is in transfer
//   cur_grant    - index of the current or most recent grant
//   pkt_done     - one-cycle pulse per port when one of its packets completes
module p4_router_ing_arbiter #(
    parameter int NUM_PORTS                    = 4,
    parameter int DATA_BYTES                   = 8,
    parameter int ING_PHYS_PORT_METADATA_WIDTH = 8,
    localparam int GW = $clog2(NUM_PORTS)
) (
    input  logic                                    clk_ifc,
    input  logic                                    sreset_ifc,
    input  logic [NUM_PORTS-1:0]                    in_tvalid,
    output logic [NUM_PORTS-1:0]                    in_tready,
    input  logic [NUM_PORTS*DATA_BYTES*8-1:0]       in_tdata,
    input  logic [NUM_PORTS*DATA_BYTES-1:0]         in_tkeep,
    input  logic [NUM_PORTS-1:0]                    in_tlast,
    output logic                                    out_tvalid,
    input  logic                                    out_tready,
    output logic [DATA_BYTES*8-1:0]                 out_tdata,
    output logic [DATA_BYTES-1:0]                   out_tkeep,
    output logic                                    out_tlast,
    output logic [ING_PHYS_PORT_METADATA_WIDTH-1:0] out_tuser,
    input  logic [NUM_PORTS-1:0]                    port_enable,
    output logic                                    busy,
    output logic [GW-1:0]                           cur_grant,
    output logic [NUM_PORTS-1:0]                    pkt_done
);

    localparam int DW = DATA_BYTES * 8;
    localparam int UW = ING_PHYS_PORT_METADATA_WIDTH;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [GW-1:0]        r_grant;
    logic [GW-1:0]        r_last_grant;
    logic [GW-1:0]        w_rr_grant;
    logic [GW-1:0]        w_cand;
    logic                 w_found;
    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] r_pkt_done;
    logic                 w_xfer;
    logic                 w_beat;
    logic                 w_eop;

    // Only ports that are both offering data and enabled compete.
    assign w_req  = in_tvalid & port_enable;
    assign w_xfer = (r_state == XFER);

    // Round-robin search: start one past the last winner and wrap, so the
    // port that just finished has the lowest priority next time round.
    // Reset leaves last_grant at NUM_PORTS-1 so port 0 wins first.
    always_comb begin
        w_found    = 1'b0;
        w_rr_grant = r_last_grant;
        w_cand     = r_last_grant;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand = GW'((int'(r_last_grant) + k) % NUM_PORTS);
            if (!w_found && w_req[w_cand]) begin
                w_found    = 1'b1;
                w_rr_grant = w_cand;
            end
        end
    end

    // The output side is a plain mux onto the granted port, so the output
    // holds steady under backpressure whenever the source does.
    assign out_tvalid = w_xfer & in_tvalid[r_grant];
    assign out_tdata  = in_tdata[r_grant*DW +: DW];
    assign out_tkeep  = in_tkeep[r_grant*DATA_BYTES +: DATA_BYTES];
    assign out_tlast  = in_tlast[r_grant];
    assign out_tuser  = UW'(r_grant);

    assign w_beat = out_tvalid & out_tready;
    assign w_eop  = w_beat & out_tlast;

    // Only the granted port sees ready, and only during a transfer.
    always_comb begin
        in_tready = '0;
        if (w_xfer) begin
            in_tready[r_grant] = out_tready;
        end
    end

    // Next state: arbitrate only in IDLE, release the bus only on tlast.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_found) w_next_state = XFER;
            XFER: if (w_eop)   w_next_state = IDLE;
            default:           w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_ifc) begin
        if (sreset_ifc) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The grant is latched for the whole packet. A port disabled mid-packet
    // therefore keeps the bus until its tlast.
    always_ff @(posedge clk_ifc) begin
        if (sreset_ifc) begin
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_PORTS - 1);
            r_pkt_done   <= '0;
        end else begin
            r_pkt_done <= '0;
            if (r_state == IDLE && w_found) begin
                r_grant      <= w_rr_grant;
                r_last_grant <= w_rr_grant;
            end
            if (w_eop) begin
                r_pkt_done[r_grant] <= 1'b1;
            end
        end
    end

    assign busy      = w_xfer;
    assign cur_grant = r_grant;
    assign pkt_done  = r_pkt_done;

endmodule
